// File: rtl/kbr_pkg.sv
// kbr_pkg: shared constants, state encoding and frame helper for the
// NeXT keyboard/mouse link responder.
package kbr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_CHK = 3'd1,
        ST_RX_BITS   = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_GAP       = 3'd4,
        ST_TX        = 3'd5
    } kbr_state_e;

    // Host command patterns, d1 in the MSB position
    localparam logic [6:0]  QUERY_KB     = 7'b0000100;
    localparam logic [6:0]  QUERY_MS     = 7'b1000100;
    localparam logic [19:0] RESET_CMD    = 20'b11110111111000000000;
    localparam logic [6:0]  RESET_PREFIX = RESET_CMD[19:13];

    // Response sent when the queried channel has nothing pending
    localparam logic [19:0] FRAME_IDLE   = 20'h80300;

    // Event response frame; bit 0 goes out first after the start bit
    function automatic logic [19:0] build_event_frame(input logic [15:0] data16);
        return {1'b0, data16[15:8], 3'b010, data16[7:0]};
    endfunction

endpackage

// File: rtl/kb_responder_if.sv
// kb_responder_if: keyboard and mouse event handshakes between the local
// event sources (master) and the responder (slave).
interface kb_responder_if;
    logic        kb_valid;
    logic [15:0] kb_data;
    logic        kb_ready;
    logic        ms_valid;
    logic [15:0] ms_data;
    logic        ms_ready;

    modport master (
        output kb_valid, kb_data, ms_valid, ms_data,
        input  kb_ready, ms_ready
    );

    modport slave (
        input  kb_valid, kb_data, ms_valid, ms_data,
        output kb_ready, ms_ready
    );
endinterface

// File: rtl/kbr_event_fifo.sv
// kbr_event_fifo: 16-bit event FIFO with flush. DEPTH=1 gives a single
// holding register; a pop and a push in the same cycle are both honoured.
module kbr_event_fifo #(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [15:0] data_i,
    input  logic        pop_i,
    output logic [15:0] data_o,
    output logic        empty_o,
    output logic        full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [15:0]   mem_q [2**AW];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o && !flush_i;
    // A flush empties the FIFO, so an event offered in that cycle still lands
    assign do_push = push_i && (flush_i || !full_o || do_pop);

    // Pointer and occupancy next-state
    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        wr_idx = wr_q;
        if (flush_i) begin
            rd_d   = '0;
            wr_idx = '0;
            wr_d   = do_push ? next_ptr('0) : '0;
            cnt_d  = do_push ? CW'(1) : '0;
        end else begin
            if (do_pop)  rd_d = next_ptr(rd_q);
            if (do_push) wr_d = next_ptr(wr_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Event storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

endmodule

// File: rtl/kb_responder.sv
// kb_responder: device side of the NeXT keyboard/mouse serial link.
// Decodes host query/reset frames on from_host and answers queries on
// to_host with an event frame or the idle frame.
// Build option: define KBR_EVENT_FIFO_EN for FIFO_DEPTH-deep event queues;
// otherwise each channel keeps a single holding register.
module kb_responder
    import kbr_pkg::*;
#(
    parameter int BIT_CLKS      = 265,
    parameter int RESP_GAP_BITS = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               from_host,
    output logic               to_host,
    kb_responder_if.slave      ev,
    output logic               initialized,
    output logic [2:0]         debug
);
`ifdef KBR_EVENT_FIFO_EN
    localparam int SLOT_DEPTH = FIFO_DEPTH;
`else
    // FIFO_DEPTH is accepted but the slot is always a single register here
    localparam int SLOT_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int TW       = $clog2(BIT_CLKS);
    localparam int GAP_CLKS = RESP_GAP_BITS * BIT_CLKS + BIT_CLKS / 2;
    localparam int GW       = $clog2(GAP_CLKS + 1);
    localparam logic [TW-1:0] LAST_T   = TW'(BIT_CLKS - 1);
    localparam logic [TW-1:0] HALF_T   = TW'(BIT_CLKS / 2 - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_START_CHK = ST_START_CHK;
    localparam logic [2:0] S_RX_BITS   = ST_RX_BITS;
    localparam logic [2:0] S_WAIT_HIGH = ST_WAIT_HIGH;
    localparam logic [2:0] S_GAP       = ST_GAP;
    localparam logic [2:0] S_TX        = ST_TX;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [18:0]   rx_q, rx_d;
    logic [19:0]   tx_q, tx_d;
    logic          to_host_q, to_host_d;
    logic          init_q, init_d;
    logic          sel_ms_q, sel_ms_d;
    logic [1:0]    sync_q;
    logic          prev_q;

    logic          line, fall, tick;
    logic [19:0]   rx_next;
    logic          flush, pop_kb, pop_ms;
    logic          kb_full, kb_empty, ms_full, ms_empty;
    logic [15:0]   kb_head, ms_head;

    assign line    = sync_q[1];
    assign fall    = prev_q && !line;
    assign tick    = (timer_q == LAST_T);
    assign rx_next = {rx_q, line};

    assign ev.kb_ready = !kb_full && !reset;
    assign ev.ms_ready = !ms_full && !reset;
    assign to_host     = to_host_q;
    assign initialized = init_q;
    assign debug       = state_q;

    kbr_event_fifo #(.DEPTH(SLOT_DEPTH)) u_kb_slot (
        .clk(clk), .rst(reset), .flush_i(flush),
        .push_i(ev.kb_valid && ev.kb_ready), .data_i(ev.kb_data),
        .pop_i(pop_kb), .data_o(kb_head), .empty_o(kb_empty), .full_o(kb_full)
    );

    kbr_event_fifo #(.DEPTH(SLOT_DEPTH)) u_ms_slot (
        .clk(clk), .rst(reset), .flush_i(flush),
        .push_i(ev.ms_valid && ev.ms_ready), .data_i(ev.ms_data),
        .pop_i(pop_ms), .data_o(ms_head), .empty_o(ms_empty), .full_o(ms_full)
    );

    // Link FSM: frame reception, response timing and transmission
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        to_host_d = to_host_q;
        init_d    = init_q;
        sel_ms_d  = sel_ms_q;
        flush     = 1'b0;
        pop_kb    = 1'b0;
        pop_ms    = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_host_d = 1'b1;
                if (fall) begin
                    state_d = S_START_CHK;
                    timer_d = '0;
                end
            end
            S_START_CHK: begin
                if (timer_q == HALF_T) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = line ? S_IDLE : S_RX_BITS;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RX_BITS: begin
                if (tick) begin
                    timer_d = '0;
                    rx_d    = rx_next[18:0];
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd6) begin
                        if (rx_next[6:0] == QUERY_KB || rx_next[6:0] == QUERY_MS) begin
                            sel_ms_d = rx_next[6];
                            if (init_q) begin
                                state_d = S_GAP;
                                gap_d   = GW'(1);
                            end else begin
                                state_d = S_WAIT_HIGH;
                            end
                        end else if (rx_next[6:0] != RESET_PREFIX) begin
                            state_d = S_WAIT_HIGH;
                        end
                    end else if (cnt_q == 5'd19) begin
                        if (rx_next == RESET_CMD) begin
                            init_d = 1'b1;
                            flush  = 1'b1;
                        end
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (!line) begin
                    timer_d = '0;
                end else if (tick) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d   = S_TX;
                    timer_d   = '0;
                    cnt_d     = '0;
                    to_host_d = 1'b0;
                    tx_d      = FRAME_IDLE;
                    if (sel_ms_q && !ms_empty) begin
                        tx_d   = build_event_frame(ms_head);
                        pop_ms = 1'b1;
                    end else if (!sel_ms_q && !kb_empty) begin
                        tx_d   = build_event_frame(kb_head);
                        pop_kb = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_TX: begin
                if (tick) begin
                    timer_d = '0;
                    if (cnt_q == 5'd20) begin
                        to_host_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        to_host_d = tx_q[0];
                        tx_d      = {1'b1, tx_q[19:1]};
                        cnt_d     = cnt_q + 5'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers and from_host synchroniser, asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            to_host_q <= 1'b1;
            init_q    <= 1'b0;
            sel_ms_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], from_host};
            prev_q    <= line;
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            to_host_q <= to_host_d;
            init_q    <= init_d;
            sel_ms_q  <= sel_ms_d;
        end
    end

    // Receive and transmit shift registers, no reset needed
    always_ff @(posedge clk) begin
        rx_q <= rx_d;
        tx_q <= tx_d;
    end

endmodule

// File: tb/tb_kb_responder.sv
// tb_kb_responder: host-side bench for kb_responder. Drives host frames,
// decodes responses and compares against a queue-based event model.
`timescale 1ns/1ps
module tb_kb_responder;
    localparam int B   = 16;
    localparam int P   = 10;
    // Start bit expected 11 bit-times after the query start, plus the
    // 2-flop synchroniser delay
    localparam int EXP_LAT = 11 * B + 2;
`ifdef KBR_EVENT_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       from_host;
    logic       to_host;
    logic       initialized;
    logic [2:0] debug;

    kb_responder_if bus();

    kb_responder #(.BIT_CLKS(B), .RESP_GAP_BITS(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .from_host(from_host), .to_host(to_host),
        .ev(bus.slave), .initialized(initialized), .debug(debug)
    );

    always #(P/2) clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] kbq[$];
    logic [15:0] msq[$];

    typedef struct {
        bit          kb_push;
        logic [15:0] kb_d;
        bit          ms_push;
        logic [15:0] ms_d;
        bit          q_ms;
        logic [19:0] exp_r;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [19:0] exp_frame(input bit has, input logic [15:0] d);
        int v;
        if (!has) return 20'h80300;
        v = int'(d[15:8]) * 2048 + 512 + int'(d[7:0]);
        return v[19:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [19:0] bits, input int n, output time t0);
        @(negedge clk);
        t0 = $time;
        from_host = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            from_host = bits[n-1-i];
            repeat (B) @(negedge clk);
        end
        from_host = 1'b1;
    endtask

    task automatic get_resp(input time t0, output bit got, output logic [19:0] r,
                            output int lat, output logic stop);
        got = 1'b0; r = '0; lat = 0; stop = 1'b0;
        for (int i = 0; i < 40 * B; i++) begin
            @(negedge clk);
            if (to_host === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            lat = int'(($time - t0) / P);
            repeat (B / 2) @(negedge clk);
            for (int k = 0; k < 20; k++) begin
                repeat (B) @(negedge clk);
                r[k] = to_host;
            end
            repeat (B) @(negedge clk);
            stop = to_host;
        end
    endtask

    task automatic query(input string nm, input bit ms, input logic [19:0] exp_r,
                         output logic [19:0] r);
        time t0; bit got; int lat; logic stop; int dl;
        send_frame(ms ? 20'h00044 : 20'h00004, 7, t0);
        get_resp(t0, got, r, lat, stop);
        check({nm, "_resp"}, 32'(got), 32'd1);
        if (got) begin
            dl = lat - EXP_LAT;
            n_cmp++;
            if (dl < -1 || dl > 1) begin
                n_err++;
                $display("FAIL %s_lat: got %0d clks expected %0d +-1", nm, lat, EXP_LAT);
            end
            check({nm, "_frame"}, 32'(r), 32'(exp_r));
            check({nm, "_stop"}, 32'(stop), 32'd1);
        end
    endtask

    task automatic expect_quiet(input string nm, input int bits);
        int lows = 0;
        for (int i = 0; i < bits * B; i++) begin
            @(negedge clk);
            if (to_host !== 1'b1) lows++;
        end
        check(nm, 32'(lows), 32'd0);
    endtask

    task automatic push(input string nm, input bit ms, input logic [15:0] d);
        bit acc; bit exp_acc;
        @(negedge clk);
        acc = ms ? bus.ms_ready : bus.kb_ready;
        if (ms) begin bus.ms_valid = 1'b1; bus.ms_data = d; end
        else    begin bus.kb_valid = 1'b1; bus.kb_data = d; end
        exp_acc = ms ? (msq.size() < DEPTH) : (kbq.size() < DEPTH);
        if (exp_acc) begin
            if (ms) msq.push_back(d); else kbq.push_back(d);
        end
        check(nm, 32'(acc), 32'(exp_acc));
        @(negedge clk);
        bus.kb_valid = 1'b0;
        bus.ms_valid = 1'b0;
    endtask

    task automatic model_query(input string nm, input bit ms);
        logic [19:0] e; logic [19:0] r;
        if (ms) e = (msq.size() > 0) ? exp_frame(1'b1, msq.pop_front()) : exp_frame(1'b0, 16'h0);
        else    e = (kbq.size() > 0) ? exp_frame(1'b1, kbq.pop_front()) : exp_frame(1'b0, 16'h0);
        query(nm, ms, e, r);
    endtask

    task automatic reset_cmd();
        time t0;
        send_frame(20'b11110111111000000000, 20, t0);
        repeat (3 * B) @(negedge clk);
        kbq.delete();
        msq.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [19:0] r;
        time t0;
        bit got;
        reset = 1'b1;
        from_host = 1'b1;
        bus.kb_valid = 1'b0; bus.kb_data = '0;
        bus.ms_valid = 1'b0; bus.ms_data = '0;

        tbl[0] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 20'h7FAFF};
        tbl[1] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 20'h00200};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 16'h8001, 1'b1, 20'h40201};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 20'h80300};
        tbl[4] = '{1'b1, 16'h1234, 1'b1, 16'h00FF, 1'b0, 20'h09234};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 20'h002FF};

        repeat (3) @(negedge clk);
        check("rst_to_host", 32'(to_host), 32'd1);
        check("rst_kb_ready", 32'(bus.kb_ready), 32'd0);
        check("rst_ms_ready", 32'(bus.ms_ready), 32'd0);
        check("rst_init", 32'(initialized), 32'd0);
        check("rst_debug", 32'(debug), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_kb_ready", 32'(bus.kb_ready), 32'd1);

        // Query before any reset command gets no answer
        send_frame(20'h00004, 7, t0);
        expect_quiet("preinit_quiet", 40);
        check("preinit_init", 32'(initialized), 32'd0);

        // Reset command with the last bit wrong is rejected
        send_frame(20'b11110111111000000001, 20, t0);
        repeat (3 * B) @(negedge clk);
        check("nearmiss_init", 32'(initialized), 32'd0);

        reset_cmd();
        check("init_set", 32'(initialized), 32'd1);
        check("init_idle", 32'(debug), 32'd0);
        query("first_idle", 1'b0, 20'h80300, r);

        push("push_3a5c", 1'b0, 16'h3A5C);
        void'(kbq.pop_front());
        query("kb_3a5c", 1'b0, 20'h1D25C, r);
        check("kb_decode", {16'h0, r[18:11], r[7:0]}, 32'h3A5C);
        check("kb_marker", 32'(r[10:8]), 32'd2);
        query("kb_second", 1'b0, 20'h80300, r);

        push("push_ms0102", 1'b1, 16'h0102);
        void'(msq.pop_front());
        query("kbq_ms_pending", 1'b0, 20'h80300, r);
        query("ms_0102", 1'b1, 20'h00A02, r);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].kb_push) begin push($sformatf("tbl%0d_kbpush", i), 1'b0, tbl[i].kb_d); kbq.delete(); end
            if (tbl[i].ms_push) begin push($sformatf("tbl%0d_mspush", i), 1'b1, tbl[i].ms_d); msq.delete(); end
            query($sformatf("tbl%0d", i), tbl[i].q_ms, tbl[i].exp_r, r);
        end

        // Short low glitch must not start a frame
        @(negedge clk);
        from_host = 1'b0;
        repeat (6) @(negedge clk);
        from_host = 1'b1;
        expect_quiet("glitch_quiet", 40);
        check("glitch_idle", 32'(debug), 32'd0);

        // Randomised traffic against the queue model
        reset_cmd();
        for (int it = 0; it < 12; it++) begin
            int nk, nm;
            nk = $urandom_range(0, 2);
            nm = $urandom_range(0, 2);
            for (int k = 0; k < nk; k++) push($sformatf("rnd%0d_kb%0d", it, k), 1'b0, 16'($urandom));
            for (int k = 0; k < nm; k++) push($sformatf("rnd%0d_ms%0d", it, k), 1'b1, 16'($urandom));
            model_query($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
        end

        // Fill a channel past capacity, drain in order, then idle
        reset_cmd();
        for (int k = 0; k <= DEPTH; k++) push($sformatf("fill%0d", k), 1'b0, 16'hA000 + 16'(k));
        for (int k = 0; k <= DEPTH; k++) model_query($sformatf("drain%0d", k), 1'b0);

        // Hardware reset in the middle of a response
        push("mid_push", 1'b0, 16'h5A5A);
        send_frame(20'h00004, 7, t0);
        got = 1'b0;
        for (int i = 0; i < 40 * B; i++) begin
            @(negedge clk);
            if (to_host === 1'b0) begin got = 1'b1; break; end
        end
        check("mid_start", 32'(got), 32'd1);
        repeat (5 * B) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_to_host", 32'(to_host), 32'd1);
        check("mid_init", 32'(initialized), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        kbq.delete();
        msq.delete();
        repeat (B) @(negedge clk);
        check("mid_idle", 32'(debug), 32'd0);
        send_frame(20'h00004, 7, t0);
        expect_quiet("mid_after_quiet", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
